// File: rtl/gfsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gfsk_pkg
//  Purpose  : Shared constants, quadrant type and sine-table generator for the
//             GFSK frequency modulator.
//  Contents : default widths, zero-deviation midpoint, filter full scale,
//             quadrant enum, constant function producing quarter-wave entries.
//  Revision : 1.0  initial release
// ============================================================================
package gfsk_pkg;

   localparam int c_phase_w = 32;
   localparam int c_lut_aw  = 8;
   localparam int c_out_w   = 12;

   // Filter full-scale output; its midpoint means zero frequency deviation.
   localparam logic [15:0] c_full_scale = 16'h2E00;
   localparam logic [15:0] c_mid        = c_full_scale >> 1;

   // pi in Q2.30 fixed point (0xC90FDAA2).
   localparam longint c_pi_q30 = 64'sd3373259426;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   // round((2^(ow-1)-1) * sin(pi/2 * (k+0.5) / 2^aw)), evaluated in Q30 with
   // a Taylor series so the table can be built at elaboration without reals.
   function automatic int sin_lut_entry(input int k, input int aw, input int ow);
      longint x;
      longint term;
      longint acc;
      longint amp;
      x    = (c_pi_q30 * longint'(2 * k + 1)) >>> (aw + 2);
      term = x;
      acc  = x;
      for (int n = 1; n <= 7; n++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         term = -(term / longint'((2 * n) * (2 * n + 1)));
         acc  = acc + term;
      end
      amp = longint'((1 << (ow - 1)) - 1);
      return int'((acc * amp + (longint'(1) << 29)) >>> 30);
   endfunction

endpackage
`default_nettype wire

// File: rtl/gfsk_freq_modulator_sin_lut.sv
`default_nettype none
// ============================================================================
//  Module   : gfsk_sin_lut
//  Purpose  : Quarter-wave sine magnitude ROM with two registered read ports.
//  Ports    : clk         - system clock
//             i_addr_sin  - quarter-wave address for the sine path
//             i_addr_cos  - quarter-wave address for the cosine path
//             o_sin_mag   - registered unsigned magnitude (sine path)
//             o_cos_mag   - registered unsigned magnitude (cosine path)
//  Revision : 1.0  initial release
// ============================================================================
module gfsk_sin_lut
   import gfsk_pkg::*;
#(
   parameter int LUT_AW = c_lut_aw,
   parameter int OUT_W  = c_out_w
)(
   input  logic              clk,
   input  logic [LUT_AW-1:0] i_addr_sin,
   input  logic [LUT_AW-1:0] i_addr_cos,
   output logic [OUT_W-2:0]  o_sin_mag,
   output logic [OUT_W-2:0]  o_cos_mag
);

   localparam int c_depth = 1 << LUT_AW;

   logic [OUT_W-2:0] w_rom [c_depth];

   // Half-step sample offset makes entry k and entry (depth-1-k) exact mirror
   // images around pi/4, so quadrant folding needs only address inversion.
   for (genvar k = 0; k < c_depth; k++) begin : g_rom
      localparam int c_val = sin_lut_entry(k, LUT_AW, OUT_W);
      assign w_rom[k] = c_val[OUT_W-2:0];
   end

   // Data path only: no reset, validity is tracked by the parent pipeline.
   always_ff @(posedge clk) begin
      o_sin_mag <= w_rom[i_addr_sin];
      o_cos_mag <= w_rom[i_addr_cos];
   end

endmodule
`default_nettype wire

// File: rtl/gfsk_freq_modulator.sv
`default_nettype none
// ============================================================================
//  Module   : gfsk_freq_modulator
//  Purpose  : Converts the Gaussian filter's unsigned shaped-bit stream into a
//             frequency deviation around a carrier, integrates it into a phase
//             accumulator and emits quadrature samples. 5-stage pipeline,
//             one sample per clock, no backpressure.
//  Ports    : clk          - system clock
//             reset_n      - asynchronous active-low reset
//             in_valid     - filtered_in carries a new sample
//             filtered_in  - unsigned filter output (MID = zero deviation)
//             phase_clr    - synchronous clear of phase and pipeline valids
//             i_out        - signed cosine sample
//             q_out        - signed sine sample
//             out_valid    - i_out/q_out updated this cycle
//             phase_out    - phase accumulator (debug)
//  Revision : 1.0  initial release
// ============================================================================
module gfsk_freq_modulator
   import gfsk_pkg::*;
#(
   parameter int                  PHASE_W     = c_phase_w,
   parameter int                  LUT_AW      = c_lut_aw,
   parameter int                  OUT_W       = c_out_w,
   parameter logic [15:0]         MID         = c_mid,
   parameter logic [PHASE_W-1:0]  CARRIER_FCW = 32'h0800_0000,
   parameter logic signed [15:0]  DEV_GAIN    = 16'sd4096,
   parameter int                  DEV_SHIFT   = 0
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   input  logic [15:0]        filtered_in,
   input  logic               phase_clr,
   output logic [OUT_W-1:0]   i_out,
   output logic [OUT_W-1:0]   q_out,
   output logic               out_valid,
   output logic [PHASE_W-1:0] phase_out
);

   // ---------------- S1: deviation and gain ----------------
   logic signed [16:0]  w_dev;
   logic signed [32:0]  w_prod;
   logic signed [32:0]  r_prod;
   logic                r_v1;

   assign w_dev  = $signed({1'b0, filtered_in}) - $signed({1'b0, MID});
   assign w_prod = 33'(w_dev) * 33'(DEV_GAIN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prod <= '0;
         r_v1   <= 1'b0;
      end else begin
         r_prod <= w_prod;
         r_v1   <= in_valid & ~phase_clr;
      end
   end

   // ---------------- S2: frequency control word ----------------
   logic signed [32:0]  w_prod_sh;
   logic [PHASE_W-1:0]  w_prod_fit;
   logic [PHASE_W-1:0]  r_fcw;
   logic                r_v2;

   assign w_prod_sh  = r_prod >>> DEV_SHIFT;
   // Signed size cast: sign-extends when PHASE_W > 33, truncates otherwise.
   assign w_prod_fit = PHASE_W'(w_prod_sh);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fcw <= '0;
         r_v2  <= 1'b0;
      end else begin
         r_fcw <= CARRIER_FCW + w_prod_fit;
         r_v2  <= r_v1 & ~phase_clr;
      end
   end

   // ---------------- S3: phase accumulator ----------------
   logic [PHASE_W-1:0]  r_phase;
   logic                r_v3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= '0;
         r_v3    <= 1'b0;
      end else begin
         if (phase_clr) begin
            r_phase <= '0;
         end else if (r_v2) begin
            r_phase <= r_phase + r_fcw;
         end
         r_v3 <= r_v2 & ~phase_clr;
      end
   end

   assign phase_out = r_phase;

   // ---------------- S4: quadrant folding and LUT read ----------------
   quad_e               w_q_sin;
   quad_e               w_q_cos;
   logic [1:0]          w_q_cos_raw;
   logic [LUT_AW-1:0]   w_addr;
   logic [LUT_AW-1:0]   w_addr_sin;
   logic [LUT_AW-1:0]   w_addr_cos;
   logic                w_sin_neg;
   logic                w_cos_neg;
   logic [OUT_W-2:0]    w_sin_mag;
   logic [OUT_W-2:0]    w_cos_mag;
   logic                r_sin_neg;
   logic                r_cos_neg;
   logic                r_v4;

   assign w_q_sin     = quad_e'(r_phase[PHASE_W-1 -: 2]);
   // cos(x) = sin(x + pi/2): one quadrant ahead.
   assign w_q_cos_raw = r_phase[PHASE_W-1 -: 2] + 2'd1;
   assign w_q_cos     = quad_e'(w_q_cos_raw);
   assign w_addr      = r_phase[PHASE_W-3 -: LUT_AW];

   // Odd quadrants run the quarter wave backwards.
   assign w_addr_sin = ((w_q_sin == Q1) || (w_q_sin == Q3)) ? ~w_addr : w_addr;
   assign w_addr_cos = ((w_q_cos == Q1) || (w_q_cos == Q3)) ? ~w_addr : w_addr;
   assign w_sin_neg  = (w_q_sin == Q2) || (w_q_sin == Q3);
   assign w_cos_neg  = (w_q_cos == Q2) || (w_q_cos == Q3);

   gfsk_sin_lut #(
      .LUT_AW (LUT_AW),
      .OUT_W  (OUT_W)
   ) u_lut (
      .clk        (clk),
      .i_addr_sin (w_addr_sin),
      .i_addr_cos (w_addr_cos),
      .o_sin_mag  (w_sin_mag),
      .o_cos_mag  (w_cos_mag)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sin_neg <= 1'b0;
         r_cos_neg <= 1'b0;
         r_v4      <= 1'b0;
      end else begin
         r_sin_neg <= w_sin_neg;
         r_cos_neg <= w_cos_neg;
         r_v4      <= r_v3 & ~phase_clr;
      end
   end

   // ---------------- S5: sign application and output ----------------
   logic [OUT_W-1:0]    w_sin_ext;
   logic [OUT_W-1:0]    w_cos_ext;
   logic [OUT_W-1:0]    w_sin_val;
   logic [OUT_W-1:0]    w_cos_val;
   logic [OUT_W-1:0]    r_i_out;
   logic [OUT_W-1:0]    r_q_out;
   logic                r_out_valid;

   assign w_sin_ext = {1'b0, w_sin_mag};
   assign w_cos_ext = {1'b0, w_cos_mag};
   assign w_sin_val = r_sin_neg ? (OUT_W'(0) - w_sin_ext) : w_sin_ext;
   assign w_cos_val = r_cos_neg ? (OUT_W'(0) - w_cos_ext) : w_cos_ext;

   // Samples only move on valid slots so bubbles leave the last value in place.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_i_out     <= '0;
         r_q_out     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_v4) begin
            r_i_out <= w_cos_val;
            r_q_out <= w_sin_val;
         end
         r_out_valid <= r_v4;
      end
   end

   assign i_out     = r_i_out;
   assign q_out     = r_q_out;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire
